nand_gate_sweeper: RTL and testbench
====================================

Name: nand_gate_sweeper

Overview:
- Parametrised hardware exerciser for NAND-built gate units. It replaces hand-written per-vector stimulus with a sequenced, self-checking sweep.
- On start, it walks every combination of two WIDTH-bit operands and holds each vector for DWELL cycles.
- At the end of each dwell window it compares the DUT result against an internal golden model built only from NAND primitives.
- It sits beside a gate DUT in simulation or on-board bring-up and reports error count, first failing vector and pass/fail.

Parameters:
- WIDTH, 1, operand width of a and b (1..4); vector count is 2^(2*WIDTH).
- DWELL, 10, cycles each vector is held before sampling (>=1).
- CNTW, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- mode  input  3  gate function to check. 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
- y_dut  input  WIDTH  DUT output, bitwise function of a_out and b_out.
- a_out  output  WIDTH  operand a driven to the DUT.
- b_out  output  WIDTH  operand b driven to the DUT.
- y_ref  output  WIDTH  golden result for the current a_out/b_out.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last sweep ended with err_cnt==0; held until the next start.
- err_cnt  output  CNTW  number of mismatching vectors, saturating.
- first_fail  output  2*WIDTH  index of the first mismatching vector.
- fail_seen  output  1  high once any mismatch has occurred in the current sweep.

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All of these go to 0: a_out, b_out, busy, done, pass, err_cnt, first_fail, fail_seen, vector index, dwell counter.
- Reset mid-sweep aborts the sweep immediately; no done pulse is generated.
- Mode handling: mode is latched at start; changing the mode input during a sweep has no effect.
- Golden model:
  - y_ref is combinational from a_out, b_out and the latched mode, built only from 2-input NAND.
  - NOT a = NAND(a,a).
  - AND = NOT(NAND).
  - OR = NAND(NOT a, NOT b).
  - NOR = NOT(OR).
  - XOR uses the 4-NAND form.
  - XNOR = NOT(XOR).
  - Modes 6 and 7 ignore b.
- Vector encoding: vector index idx has 2*WIDTH bits. a_out = idx[2W-1:W], b_out = idx[W-1:0]. For WIDTH=1 the order is 00, 01, 10, 11.
- IDLE:
  - busy=0. On start=1: latch mode, idx=0, dwell=0, clear err_cnt/first_fail/fail_seen/pass, go to RUN.
  - a_out/b_out take vector 0 on the same edge.
- RUN:
  - busy=1. The dwell counter increments each cycle.
  - On the cycle where dwell==DWELL-1, y_dut is compared against y_ref.
  - On mismatch: err_cnt increments (holds at 2^CNTW-1, no wrap). If fail_seen==0, first_fail<=idx and fail_seen<=1.
  - Also on that cycle: if idx == all-ones, go to FINISH. Otherwise idx+1, dwell<=0, and a_out/b_out update on the same edge.
- FINISH:
  - Lasts one cycle: done=1, busy=0, pass<=(final err_cnt==0). Then go to IDLE.
  - a_out/b_out hold the last vector.
- Latency:
  - start sampled at edge 0; vector 0 visible after edge 0.
  - Each vector lasts exactly DWELL cycles.
  - done is high during the cycle after the final compare.
  - busy is high for exactly 2^(2W)*DWELL cycles.
- Simultaneous events:
  - rst has priority over everything.
  - start while busy or while done is high is ignored.
  - start held high continuously re-launches a new sweep one cycle after each done.
- DWELL=1: compare on every cycle; y_dut must settle within one cycle.
- err_cnt, first_fail, fail_seen and pass remain valid in IDLE until the next start or rst.

Test Plan:
- Correct AND DUT (WIDTH=1, DWELL=10, mode=1), start pulsed at cycle 0:
  - a/b step through 00, 01, 10, 11, each held 10 cycles; busy high for 40 cycles.
  - done pulses once; err_cnt=0, pass=1, fail_seen=0.
- y_dut stuck at 0 (mode=2 OR, WIDTH=1) -> err_cnt=3, first_fail=1, fail_seen=1, pass=0.
- WIDTH=2, DWELL=1, mode=4 XOR with correct DUT:
  - 16 vectors, busy for 16 cycles, y_ref=a^b each cycle, err_cnt=0, pass=1.
- Abort, then normal sweep:
  - Assert rst during vector 2 -> next cycle all outputs are 0, state IDLE, no done.
  - A following start runs a full clean sweep from vector 0.
- Ignored inputs (mode=0 NAND, correct DUT):
  - start re-pulsed and mode changed to 3 mid-sweep -> sweep continues with NAND unaltered.
  - Exactly one done pulse; err_cnt=0.
- CNTW=2, WIDTH=2, y_dut inverted from the correct result on every vector -> err_cnt saturates at 3 (no wrap), first_fail=0, pass=0.

Source files
------------

// File: rtl/nand_gate_sweeper.sv
// Self-checking exerciser for NAND-built gate units: sweeps every (a, b) operand pair,
// dwells DWELL cycles per vector and compares the DUT against a NAND-only golden model.
module nand_gate_sweeper #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DWELL = 10,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     y_dut,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic [WIDTH-1:0]     y_ref,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNTW-1:0]      err_cnt,
    output logic [2*WIDTH-1:0]   first_fail,
    output logic                 fail_seen
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e            r_state;
    logic [2:0]        r_mode;
    logic [IW-1:0]     r_idx;
    logic [DW-1:0]     r_dwell;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNTW-1:0]   r_err;
    logic [IW-1:0]     r_first;
    logic              r_fail_seen;

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_not_a;
    logic [WIDTH-1:0]  w_not_b;
    logic [WIDTH-1:0]  w_nand;
    logic [WIDTH-1:0]  w_and;
    logic [WIDTH-1:0]  w_or;
    logic [WIDTH-1:0]  w_nor;
    logic [WIDTH-1:0]  w_xor;
    logic [WIDTH-1:0]  w_xnor;
    logic [WIDTH-1:0]  w_buf;
    logic              w_last_dwell;
    logic              w_last_vec;
    logic              w_mismatch;

    function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return ~(x & y);
    endfunction

    assign w_a = r_idx[IW-1:WIDTH];
    assign w_b = r_idx[WIDTH-1:0];

    // Every golden function is composed from the nand2 primitive only.
    assign w_not_a = nand2(w_a, w_a);
    assign w_not_b = nand2(w_b, w_b);
    assign w_nand  = nand2(w_a, w_b);
    assign w_and   = nand2(w_nand, w_nand);
    assign w_or    = nand2(w_not_a, w_not_b);
    assign w_nor   = nand2(w_or, w_or);
    assign w_xor   = nand2(nand2(w_a, w_nand), nand2(w_b, w_nand));
    assign w_xnor  = nand2(w_xor, w_xor);
    assign w_buf   = nand2(w_not_a, w_not_a);

    always_comb begin
        y_ref = w_nand;
        case (r_mode)
            3'd0:    y_ref = w_nand;
            3'd1:    y_ref = w_and;
            3'd2:    y_ref = w_or;
            3'd3:    y_ref = w_nor;
            3'd4:    y_ref = w_xor;
            3'd5:    y_ref = w_xnor;
            3'd6:    y_ref = w_not_a;
            default: y_ref = w_buf;
        endcase
    end

    assign w_last_dwell = (r_dwell == DW'(DWELL - 1));
    assign w_last_vec   = (r_idx == {IW{1'b1}});
    assign w_mismatch   = (y_dut != y_ref);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_mode      <= 3'd0;
            r_idx       <= '0;
            r_dwell     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_first     <= '0;
            r_fail_seen <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_idx       <= '0;
                        r_dwell     <= '0;
                        r_err       <= '0;
                        r_first     <= '0;
                        r_fail_seen <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= StRun;
                    end
                end
                StRun: begin
                    if (w_last_dwell) begin
                        if (w_mismatch) begin
                            if (r_err != {CNTW{1'b1}}) begin
                                r_err <= r_err + CNTW'(1);
                            end
                            if (!r_fail_seen) begin
                                r_first     <= r_idx;
                                r_fail_seen <= 1'b1;
                            end
                        end
                        if (w_last_vec) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StFinish;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_dwell <= '0;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                StFinish: begin
                    // r_err already includes the final vector's compare here.
                    r_pass  <= (r_err == '0);
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign a_out      = w_a;
    assign b_out      = w_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err;
    assign first_fail = r_first;
    assign fail_seen  = r_fail_seen;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// Bench for nand_gate_sweeper: two instances (W=1/D=10/C=16 and W=2/D=1/C=2), a behavioural
// gate DUT per instance, and queue-based scoreboards for per-cycle vectors and sweep results.
module tb_nand_gate_sweeper;

    localparam int unsigned AW = 1;
    localparam int unsigned AD = 10;
    localparam int unsigned AC = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned BD = 1;
    localparam int unsigned BC = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    typedef struct packed {
        logic [15:0] err;
        logic [3:0]  ff;
        logic        fs;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              ua_rst, ua_start;
    logic [2:0]        ua_mode, ua_dut_mode;
    logic [AW-1:0]     ua_y_dut, ua_a_out, ua_b_out, ua_y_ref;
    logic              ua_busy, ua_done, ua_pass, ua_fail_seen;
    logic [AC-1:0]     ua_err_cnt;
    logic [2*AW-1:0]   ua_first_fail;
    int                ua_fault;
    logic [3:0]        ua_good;

    logic              ub_rst, ub_start;
    logic [2:0]        ub_mode, ub_dut_mode;
    logic [BW-1:0]     ub_y_dut, ub_a_out, ub_b_out, ub_y_ref;
    logic              ub_busy, ub_done, ub_pass, ub_fail_seen;
    logic [BC-1:0]     ub_err_cnt;
    logic [2*BW-1:0]   ub_first_fail;
    int                ub_fault;
    logic [3:0]        ub_good;

    vec_t qa_vec[$];
    vec_t qb_vec[$];
    res_t qa_res[$];
    res_t qb_res[$];

    int n_checks = 0;
    int n_errors = 0;
    int da_count = 0;
    int db_count = 0;
    logic exp_pass[2];

    nand_gate_sweeper #(.WIDTH(AW), .DWELL(AD), .CNTW(AC)) u_dut_a (
        .clk(clk), .rst(ua_rst), .start(ua_start), .mode(ua_mode), .y_dut(ua_y_dut),
        .a_out(ua_a_out), .b_out(ua_b_out), .y_ref(ua_y_ref), .busy(ua_busy),
        .done(ua_done), .pass(ua_pass), .err_cnt(ua_err_cnt), .first_fail(ua_first_fail),
        .fail_seen(ua_fail_seen)
    );

    nand_gate_sweeper #(.WIDTH(BW), .DWELL(BD), .CNTW(BC)) u_dut_b (
        .clk(clk), .rst(ub_rst), .start(ub_start), .mode(ub_mode), .y_dut(ub_y_dut),
        .a_out(ub_a_out), .b_out(ub_b_out), .y_ref(ub_y_ref), .busy(ub_busy),
        .done(ub_done), .pass(ub_pass), .err_cnt(ub_err_cnt), .first_fail(ub_first_fail),
        .fail_seen(ub_fail_seen)
    );

    function automatic logic [3:0] gate(input logic [2:0] m, input logic [3:0] x,
                                        input logic [3:0] y);
        case (m)
            3'd0:    return ~(x & y);
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Behavioural gate under test; fault 1 = output stuck at 0, fault 2 = inverted.
    always_comb begin
        ua_good = gate(ua_dut_mode, {3'b0, ua_a_out}, {3'b0, ua_b_out});
        ub_good = gate(ub_dut_mode, {2'b0, ub_a_out}, {2'b0, ub_b_out});
        ua_y_dut = (ua_fault == 1) ? 1'b0 : (ua_fault == 2) ? ~ua_good[0] : ua_good[0];
        ub_y_dut = (ub_fault == 1) ? 2'b0 : (ub_fault == 2) ? ~ub_good[1:0] : ub_good[1:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pushes the expected per-cycle vectors and the final sweep result for one instance.
    task automatic plan(input int inst, input logic [2:0] m, input int fault);
        int w, d, sat, n;
        logic [3:0] mask, a, b, y, yd;
        res_t r;
        w    = (inst == 0) ? AW : BW;
        d    = (inst == 0) ? AD : BD;
        sat  = (inst == 0) ? 65535 : 3;
        n    = 1 << (2 * w);
        mask = 4'((1 << w) - 1);
        r    = '0;
        for (int idx = 0; idx < n; idx++) begin
            a  = 4'(idx >> w) & mask;
            b  = 4'(idx) & mask;
            y  = gate(m, a, b) & mask;
            yd = (fault == 0) ? y : (fault == 1) ? 4'd0 : (~y & mask);
            for (int k = 0; k < d; k++) begin
                if (inst == 0) qa_vec.push_back('{a: a, b: b, y: y});
                else           qb_vec.push_back('{a: a, b: b, y: y});
            end
            if (yd != y) begin
                if (int'(r.err) < sat) r.err = r.err + 16'd1;
                if (!r.fs) begin
                    r.ff = 4'(idx);
                    r.fs = 1'b1;
                end
            end
        end
        r.pass = (r.err == 16'd0);
        exp_pass[inst] = r.pass;
        if (inst == 0) qa_res.push_back(r);
        else           qb_res.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!ua_rst) begin
            if (ua_busy) begin
                if (qa_vec.size() == 0) begin
                    check("a_busy_overrun", 32'(ua_busy), 32'd0);
                end else begin
                    vec_t e;
                    e = qa_vec.pop_front();
                    check("a_a_out", 32'(ua_a_out), 32'(e.a));
                    check("a_b_out", 32'(ua_b_out), 32'(e.b));
                    check("a_y_ref", 32'(ua_y_ref), 32'(e.y));
                end
            end
            if (ua_done) begin
                da_count++;
                check("a_busy_short", 32'(qa_vec.size()), 32'd0);
                check("a_busy_at_done", 32'(ua_busy), 32'd0);
                if (qa_res.size() == 0) begin
                    check("a_done_unexpected", 32'(ua_done), 32'd0);
                end else begin
                    res_t r;
                    r = qa_res.pop_front();
                    check("a_err_cnt", 32'(ua_err_cnt), 32'(r.err));
                    check("a_first_fail", 32'(ua_first_fail), 32'(r.ff));
                    check("a_fail_seen", 32'(ua_fail_seen), 32'(r.fs));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!ub_rst) begin
            if (ub_busy) begin
                if (qb_vec.size() == 0) begin
                    check("b_busy_overrun", 32'(ub_busy), 32'd0);
                end else begin
                    vec_t e;
                    e = qb_vec.pop_front();
                    check("b_a_out", 32'(ub_a_out), 32'(e.a));
                    check("b_b_out", 32'(ub_b_out), 32'(e.b));
                    check("b_y_ref", 32'(ub_y_ref), 32'(e.y));
                end
            end
            if (ub_done) begin
                db_count++;
                check("b_busy_short", 32'(qb_vec.size()), 32'd0);
                check("b_busy_at_done", 32'(ub_busy), 32'd0);
                if (qb_res.size() == 0) begin
                    check("b_done_unexpected", 32'(ub_done), 32'd0);
                end else begin
                    res_t r;
                    r = qb_res.pop_front();
                    check("b_err_cnt", 32'(ub_err_cnt), 32'(r.err));
                    check("b_first_fail", 32'(ub_first_fail), 32'(r.ff));
                    check("b_fail_seen", 32'(ub_fail_seen), 32'(r.fs));
                end
            end
        end
    end

    task automatic launch(input int inst, input logic [2:0] m, input int fault);
        @(posedge clk) #1;
        plan(inst, m, fault);
        if (inst == 0) begin
            ua_mode = m; ua_dut_mode = m; ua_fault = fault; ua_start = 1'b1;
        end else begin
            ub_mode = m; ub_dut_mode = m; ub_fault = fault; ub_start = 1'b1;
        end
        @(posedge clk) #1;
        ua_start = 1'b0;
        ub_start = 1'b0;
    endtask

    // Waits for done (bounded), then checks pass and the done pulse count one cycle later.
    task automatic finish_sweep(input int inst);
        int n, d0;
        logic dn;
        n  = 0;
        d0 = (inst == 0) ? da_count : db_count;
        dn = (inst == 0) ? ua_done : ub_done;
        while (!dn && n < 2000) begin
            @(negedge clk);
            n++;
            dn = (inst == 0) ? ua_done : ub_done;
        end
        check("done_timeout", 32'(dn), 32'd1);
        @(negedge clk);
        if (inst == 0) begin
            check("a_pass", 32'(ua_pass), 32'(exp_pass[0]));
            check("a_done_pulses", 32'(da_count - d0), 32'd1);
            check("a_idle_busy", 32'(ua_busy), 32'd0);
        end else begin
            check("b_pass", 32'(ub_pass), 32'(exp_pass[1]));
            check("b_done_pulses", 32'(db_count - d0), 32'd1);
            check("b_idle_busy", 32'(ub_busy), 32'd0);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_a_out"}, 32'(ua_a_out), 32'd0);
        check({tag, "_b_out"}, 32'(ua_b_out), 32'd0);
        check({tag, "_busy"}, 32'(ua_busy), 32'd0);
        check({tag, "_done"}, 32'(ua_done), 32'd0);
        check({tag, "_pass"}, 32'(ua_pass), 32'd0);
        check({tag, "_err"}, 32'(ua_err_cnt), 32'd0);
        check({tag, "_ff"}, 32'(ua_first_fail), 32'd0);
        check({tag, "_fs"}, 32'(ua_fail_seen), 32'd0);
    endtask

    initial begin
        int d0;
        ua_rst = 1'b1; ua_start = 1'b0; ua_mode = 3'd0; ua_dut_mode = 3'd0; ua_fault = 0;
        ub_rst = 1'b1; ub_start = 1'b0; ub_mode = 3'd0; ub_dut_mode = 3'd0; ub_fault = 0;
        repeat (2) @(posedge clk);
        #1;
        check_a_zero("rst");
        check("rst_b_busy", 32'(ub_busy), 32'd0);
        check("rst_b_err", 32'(ub_err_cnt), 32'd0);
        check("rst_b_out", 32'({ub_a_out, ub_b_out}), 32'd0);
        ua_rst = 1'b0;
        ub_rst = 1'b0;

        // Correct AND, then OR against a stuck-at-0 output.
        launch(0, 3'd1, 0);
        finish_sweep(0);
        launch(0, 3'd2, 1);
        finish_sweep(0);

        // Reset during vector 2 aborts with no done pulse.
        launch(0, 3'd1, 0);
        repeat (2 * AD + 3) @(negedge clk);
        d0 = da_count;
        @(posedge clk) #1;
        ua_rst = 1'b1;
        @(posedge clk) #1;
        ua_rst = 1'b0;
        qa_vec.delete();
        qa_res.delete();
        check_a_zero("abort");
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(da_count - d0), 32'd0);
        check("abort_idle", 32'(ua_busy), 32'd0);

        // Clean sweep after the abort.
        launch(0, 3'd1, 0);
        finish_sweep(0);

        // start re-pulse and mode change mid-sweep must be ignored.
        launch(0, 3'd0, 0);
        repeat (15) @(negedge clk);
        @(posedge clk) #1;
        ua_start = 1'b1;
        ua_mode  = 3'd3;
        @(posedge clk) #1;
        ua_start = 1'b0;
        finish_sweep(0);
        ua_mode = 3'd0;

        // WIDTH=2, DWELL=1: correct XOR, then XNOR with an inverted DUT (saturating counter).
        launch(1, 3'd4, 0);
        finish_sweep(1);
        launch(1, 3'd5, 2);
        finish_sweep(1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
